// File: rtl/cnt_en_gen_if.sv
// Button/divisor inputs and enable outputs of the counter enable generator.
interface cnt_en_gen_if #(
    parameter int unsigned DIV_W = 16
);
    logic             btn_run;
    logic             btn_step;
    logic [DIV_W-1:0] div;
    logic             ci;
    logic             running;

    modport master (
        output btn_run,
        output btn_step,
        output div,
        input  ci,
        input  running
    );

    modport slave (
        input  btn_run,
        input  btn_step,
        input  div,
        output ci,
        output running
    );
endinterface

// File: rtl/cnt_en_gen.sv
// Counter enable generator: debounced run/step buttons drive a STOP/RUN/STEP
// machine; in RUN a prescaler emits one ci pulse every div+1 clocks.
module cnt_en_gen #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    cnt_en_gen_if.slave  bus
);
    localparam int unsigned DB_CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned NBTN    = 2;
    localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // Bit 0 is the run button, bit 1 the step button.
    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  stable;
    logic [NBTN-1:0]  stable_q;
    logic [DB_CW-1:0] dbcnt [NBTN];
    logic [NBTN-1:0]  press;
    logic             run_press;
    logic             step_press;

    state_t           state;
    logic [DIV_W-1:0] pcnt;
    logic             term;

    assign raw        = {bus.btn_step, bus.btn_run};
    assign press      = stable & ~stable_q;
    assign run_press  = press[0];
    assign step_press = press[1];
    assign term       = (pcnt >= bus.div);

    // Two-flop synchroniser, per-button debounce counter and edge-detect delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                dbcnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2[i] == stable[i]) begin
                    dbcnt[i] <= '0;
                end else if (dbcnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    dbcnt[i]  <= '0;
                end else begin
                    dbcnt[i] <= dbcnt[i] + DB_CW'(1);
                end
            end
        end
    end

    // STOP/RUN/STEP machine with prescaler and registered ci/running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_STOP;
            pcnt        <= '0;
            bus.ci      <= 1'b0;
            bus.running <= 1'b0;
        end else begin
            // A terminal count on the same cycle as a stop press still fires.
            bus.ci <= (state == ST_STEP) || ((state == ST_RUN) && term);
            case (state)
                ST_STOP: begin
                    bus.running <= run_press;
                    if (run_press) begin
                        state <= ST_RUN;
                        pcnt  <= '0;
                    end else if (step_press) begin
                        state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    // >= lets a lowered divisor end the period without wrapping.
                    pcnt        <= term ? '0 : pcnt + DIV_W'(1);
                    bus.running <= !run_press;
                    if (run_press) begin
                        state <= ST_STOP;
                    end
                end
                ST_STEP: begin
                    state       <= ST_STOP;
                    bus.running <= 1'b0;
                end
                default: begin
                    state       <= ST_STOP;
                    bus.running <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnt_en_gen.sv
// Scoreboard bench for cnt_en_gen: stimulus pushes the cycle numbers at which
// ci must be high; a negedge monitor pops and compares every ci pulse.
module tb_cnt_en_gen;
    localparam int unsigned DIV_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cnt_en_gen_if #(.DIV_W(DIV_W)) bus ();

    cnt_en_gen #(.DIV_W(DIV_W), .DB_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q [$];

    // Downstream 8-bit counter fed by ci, sharing clk and rst.
    logic [7:0] q_cnt;
    int         co_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_cnt <= 8'h00;
        end else if (bus.ci) begin
            if (q_cnt == 8'hFF) co_cnt <= co_cnt + 1;
            q_cnt <= q_cnt + 8'h01;
        end
    end

    // Monitor: every ci pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.ci) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ci_unexpected: pulse at cycle %0d, none expected", cyc);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (e != cyc) begin
                        failures++;
                        $display("FAIL ci_timing: pulse at cycle %0d, expected cycle %0d", cyc, e);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
                int e;
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL ci_missing: no pulse at cycle %0d (expected %0d)", cyc, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int first, input int last, input int step);
        for (int c = first; c <= last; c += step) exp_q.push_back(c);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin
        int n;
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        bus.div      = 16'd3;

        // Reset state.
        #1;
        check("reset_ci", int'(bus.ci), 0);
        check("reset_running", int'(bus.running), 0);
        #14 rst = 1'b1;
        tick(20);
        check("idle_ci", int'(bus.ci), 0);
        check("idle_running", int'(bus.running), 0);
        check("idle_q", int'(q_cnt), 0);

        // Single step: one pulse 7 clocks after the first sampling edge.
        n = cyc;
        exp_q.push_back(n + 8);
        bus.btn_step = 1'b1;
        tick(9);
        check("step_running", int'(bus.running), 0);
        tick(1);
        bus.btn_step = 1'b0;
        tick(10);
        check("step_q", int'(q_cnt), 1);

        // Debounce: short pulse and 1-clock bounces are rejected.
        bus.btn_step = 1'b1; tick(2);
        bus.btn_step = 1'b0; tick(1);
        for (int k = 0; k < 2; k++) begin
            bus.btn_step = 1'b1; tick(1);
            bus.btn_step = 1'b0; tick(1);
        end
        tick(12);
        check("bounce_q", int'(q_cnt), 1);
        n = cyc;
        exp_q.push_back(n + 8);
        bus.btn_step = 1'b1; tick(6);
        bus.btn_step = 1'b0; tick(12);
        check("debounce_q", int'(q_cnt), 2);

        // RUN with div=3: ci every 4th clock, stop on second press.
        bus.div = 16'd3;
        n = cyc;
        push_range(n + 11, n + 55, 4);
        bus.btn_run = 1'b1;
        tick(8);
        check("run_running", int'(bus.running), 1);
        tick(2);
        bus.btn_run = 1'b0;
        tick(38);
        check("run_q40", int'(q_cnt), 12);
        bus.btn_run = 1'b1;
        tick(8);
        check("stop_running", int'(bus.running), 0);
        tick(2);
        bus.btn_run = 1'b0;
        tick(20);
        check("stop_q_holds", int'(q_cnt), 14);

        // div=0: ci every clock, counter wraps once through 8'hFF.
        bus.div = 16'd0;
        n = cyc;
        push_range(n + 8, n + 257, 1);
        bus.btn_run = 1'b1; tick(10);
        bus.btn_run = 1'b0; tick(240);
        bus.btn_run = 1'b1; tick(10);
        bus.btn_run = 1'b0; tick(15);
        check("div0_q", int'(q_cnt), 8);
        check("div0_co", co_cnt, 1);

        // div lowered 10 -> 2 while pcnt=7: fire next clock, then every 3.
        bus.div = 16'd10;
        n = cyc;
        exp_q.push_back(n + 15);
        push_range(n + 18, n + 37, 3);
        bus.btn_run = 1'b1; tick(10);
        bus.btn_run = 1'b0; tick(4);
        bus.div = 16'd2;
        tick(16);
        bus.btn_run = 1'b1; tick(10);
        bus.btn_run = 1'b0; tick(15);
        check("divsw_q", int'(q_cnt), 16);
        check("divsw_running", int'(bus.running), 0);

        // Run and step together from STOP: run wins, no step pulse.
        bus.div = 16'd0;
        n = cyc;
        push_range(n + 8, n + 19, 1);
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        tick(10);
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        tick(10);
        check("both_q", int'(q_cnt), 28);
        check("both_running", int'(bus.running), 1);

        // Reset mid-RUN drops ci and running immediately.
        rst = 1'b0;
        #1;
        check("midrst_ci", int'(bus.ci), 0);
        check("midrst_running", int'(bus.running), 0);
        tick(2);
        rst = 1'b1;
        tick(15);
        check("postrst_running", int'(bus.running), 0);

        // Machine is back in STOP: a step gives exactly one pulse.
        n = cyc;
        exp_q.push_back(n + 8);
        bus.btn_step = 1'b1; tick(10);
        bus.btn_step = 1'b0; tick(12);
        check("postrst_step_q", int'(q_cnt), 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
